ln_row_packer: RTL
==================

// Module: ln_row_packer
// PURPOSE
//  Stage directly upstream of the 64 x FP16 layer-norm datapath.
//  - Accepts a narrow valid/ready element stream of LANES FP16 values per beat.
//  - Assembles 64-element rows and presents each complete row as one vector.
//  - Output drives the LN x_valid / a / adder_input_ready handshake.
//  - Double-buffered (ping-pong): one row can fill while the previous row waits on LN back-pressure.
// PARAMETERS
//  VEC_LEN   64   elements per row (LN vector length)
//  DATA_W    16   element width (FP16, passed through untouched)
//  LANES     4    elements per input beat; must divide VEC_LEN
//  CNT_W     16   width of row_count
//  Derived: BEATS = VEC_LEN/LANES (16 at defaults), BCNT_W = clog2(BEATS)
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  s_valid    in   1               input beat valid
//  s_data     in   LANES*DATA_W    lane j = bits [j*DATA_W +: DATA_W]
//  s_last     in   1               marks final beat of a row
//  s_ready    out  1               input beat accepted when s_valid & s_ready
//  m_valid    out  1               complete row available (-> LN x_valid)
//  m_data     out  VEC_LEN*DATA_W  row; element e = bits [e*DATA_W +: DATA_W] (-> LN a)
//  m_ready    in   1               LN ready (<- adder_input_ready)
//  err_short  out  1               1-cycle pulse: row truncated by an early s_last, row dropped
//  err_long   out  1               1-cycle pulse: final beat arrived without s_last
//  row_count  out  CNT_W           rows delivered (m handshakes), wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset
//  - During rst: s_ready=0.
//  - After rst: m_valid=0, err_*=0, row_count=0, both buffers EMPTY.
//  - After rst: wbuf=rbuf=0, beat_cnt=0, FSM=FILL.
//  - m_data reads 0; s_ready=1 in the first cycle after rst deasserts.
//  Element placement
//  - Beat k (0..BEATS-1), lane j -> element k*LANES+j.
//  - Data is a bit-exact copy; no arithmetic.
//  Buffer flags
//  - full[1:0] per buffer.
//  - s_ready = !rst & (FSM==DRAIN | !full[wbuf]). Registered terms only; no combinational m_ready->s_ready path.
//  FSM FILL (beat accepted)
//  - Write lanes into buf[wbuf] at beat_cnt.
//  - If beat_cnt==BEATS-1: set full[wbuf], toggle wbuf, reset beat_cnt=0.
//    - If s_last was set: stay in FILL.
//    - If s_last was clear: pulse err_long and go to DRAIN.
//  - Else if s_last: pulse err_short, reset beat_cnt=0, buffer stays EMPTY (row discarded), stay in FILL.
//  - Else: beat_cnt++.
//  FSM DRAIN
//  - Accept and discard beats (s_ready=1) until a beat with s_last, then go to FILL. No buffer writes.
//  Output
//  - m_valid = full[rbuf]; m_data = buf[rbuf].
//  - m_data holds stable while m_valid & !m_ready.
//  - On m_valid & m_ready: clear full[rbuf], toggle rbuf, row_count++.
//  Latency and throughput
//  - Final beat accepted at cycle t -> m_valid=1 at t+1 (if rbuf points to that buffer).
//  - Sustains 1 beat/clk, i.e. one row per BEATS clocks, with m_ready=1.
//  Simultaneous events
//  - Read-release and final write in the same cycle are legal when they hit different buffers.
//  - A buffer freed in cycle t becomes writable (s_ready) at t+1.
//  - Both buffers full -> s_ready=0; a partial row is never overwritten.
//  Reset mid-operation
//  - Partial and full rows are discarded and nothing is emitted.
//  - row_count returns to 0.
// STRUCTURE
//  - Shared package ln_pkg: VEC_LEN, FP16_W, LANES, BEATS constants; FSM enum {FILL, DRAIN}.
//    The LN datapath uses the same VEC_LEN/FP16_W.
//  - One natural sub-module, ln_row_buf: one VEC_LEN*DATA_W register with beat-indexed LANES-wide write enable.
//  - Instantiate ln_row_buf twice. Flags, pointers and FSM stay in the top.
// TESTING
//  1. Reset, then 16 beats of elements 0..63 (value = 16'h3C00 + e), s_last on beat 15, m_ready=1
//     -> m_valid one clk after beat 15; element e = 16'h3C00+e; row_count=1.
//  2. m_ready=0, send 3 back-to-back rows -> rows 1-2 accepted.
//     s_ready=0 from the clk after row 2's final beat through row 3's first beat.
//     m_data stays row 1; raising m_ready drains rows 1, 2, then row 3, all in order, none lost.
//  3. s_last on beat 5 -> err_short pulses once, no m_valid.
//     The next full row is delivered intact with element 0 = first beat after the error.
//  4. 20 beats with s_last on beat 19 -> row of beats 0-15 delivered.
//     err_long pulses on beat 15; beats 16-19 are dropped; the next row packs correctly.
//  5. Continuous stream, m_ready=1, 8 rows -> s_ready never drops; m_valid once per 16 clks; row_count=8.
//  6. Assert rst for 1 clk mid-row (beat 9) with a full row pending
//     -> m_valid=0, row_count=0, both buffers empty; the next complete row is delivered correctly.

Source files
------------

// File: rtl/ln_pkg.sv
// Shared layer-norm constants and the row packer control-state type.
// The LN datapath uses the same VEC_LEN and FP16_W values.
package ln_pkg;

  localparam int VEC_LEN = 64;
  localparam int FP16_W  = 16;
  localparam int LANES   = 4;
  localparam int BEATS   = VEC_LEN / LANES;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } ln_state_e;

endpackage

// File: rtl/ln_row_buf.sv
// One row of VEC_LEN elements, written LANES elements at a time at a beat index.
// Read side is a plain continuous view of the stored row.
module ln_row_buf #(
  parameter int VEC_LEN = 64,
  parameter int DATA_W  = 16,
  parameter int LANES   = 4
) (
  input  logic                                      clk,
  input  logic                                      we,
  input  logic [((VEC_LEN/LANES > 1) ? $clog2(VEC_LEN/LANES) : 1)-1:0] beat_idx,
  input  logic [LANES*DATA_W-1:0]                   wdata,
  output logic [VEC_LEN*DATA_W-1:0]                 row
);

  localparam int BEATS  = VEC_LEN / LANES;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_W = LANES * DATA_W;

  logic [VEC_LEN*DATA_W-1:0] row_q;

  // NOTE: row storage has no reset; validity lives in the owner's full flags,
  // and the owner masks the read data while the row is not valid.
  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    always_ff @(posedge clk) begin
      if (we && beat_idx == BCNT_W'(b)) begin
        row_q[b*BEAT_W +: BEAT_W] <= wdata;
      end
    end
  end

  assign row = row_q;

endmodule

// File: rtl/ln_row_packer.sv
// Packs a LANES-wide element stream into VEC_LEN-element rows for the LN datapath,
// ping-ponging between two row buffers so one fills while the other waits on m_ready.
module ln_row_packer #(
  parameter int VEC_LEN = 64,
  parameter int DATA_W  = 16,
  parameter int LANES   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [LANES*DATA_W-1:0]    s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [VEC_LEN*DATA_W-1:0]  m_data,
  input  logic                       m_ready,
  output logic                       err_short,
  output logic                       err_long,
  output logic [CNT_W-1:0]           row_count
);

  import ln_pkg::ln_state_e;
  import ln_pkg::FILL;
  import ln_pkg::DRAIN;

  localparam int BEATS  = VEC_LEN / LANES;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W  = VEC_LEN * DATA_W;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  ln_state_e         state;
  logic [1:0]        full;
  logic              wbuf;
  logic              rbuf;
  logic [BCNT_W-1:0] beat_cnt;

  logic              accept;
  logic              fill_beat;
  logic              final_beat;
  logic              rd_done;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;
  logic [ROW_W-1:0]  row0;
  logic [ROW_W-1:0]  row1;

  // Only registered state (plus reset) feeds s_ready; m_ready never reaches it.
  assign s_ready    = !rst && (state == DRAIN || !full[wbuf]);
  assign accept     = s_valid && s_ready;
  assign fill_beat  = accept && state == FILL;
  assign final_beat = fill_beat && beat_cnt == LAST_BEAT;

  assign m_valid    = full[rbuf];
  assign rd_done    = m_valid && m_ready;
  assign m_data     = m_valid ? (rbuf ? row1 : row0) : '0;

  ln_row_buf #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .LANES(LANES)) u_buf0 (
    .clk      (clk),
    .we       (fill_beat && !wbuf),
    .beat_idx (beat_cnt),
    .wdata    (s_data),
    .row      (row0)
  );

  ln_row_buf #(.VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .LANES(LANES)) u_buf1 (
    .clk      (clk),
    .we       (fill_beat && wbuf),
    .beat_idx (beat_cnt),
    .wdata    (s_data),
    .row      (row1)
  );

  // A completing write and a read release always target different buffers,
  // because the writer only fills an empty buffer and the reader only frees a full one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    full_set = '0;
    full_clr = '0;
    if (final_beat) full_set[wbuf] = 1'b1;
    if (rd_done)    full_clr[rbuf] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      full      <= '0;
      wbuf      <= 1'b0;
      rbuf      <= 1'b0;
      beat_cnt  <= '0;
      row_count <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      full      <= (full & ~full_clr) | full_set;
      err_short <= 1'b0;
      err_long  <= 1'b0;

      if (rd_done) begin
        rbuf      <= ~rbuf;
        row_count <= row_count + 1'b1;
      end

      if (accept) begin
        case (state)
          FILL: begin
            if (beat_cnt == LAST_BEAT) begin
              wbuf     <= ~wbuf;
              beat_cnt <= '0;
              if (!s_last) begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end
            end else if (s_last) begin
              // Truncated row: the buffer was never marked full, so it is simply refilled.
              err_short <= 1'b1;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
          DRAIN: begin
            if (s_last) state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule
